// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared constants and state encoding for the fetch stage
//   STALL_PC/STALL_IF/STALL_ID : bit positions inside the ctrl stall vector
//   NOP_INST_DEFAULT           : instruction placed on IF/ID for bubbles and flushes
//   fetch_state_e              : FETCH / HOLD / DROP
package inst_fetch_pkg;

    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - instruction-memory read handshake
//   imem_req   : read request (master -> slave)
//   imem_addr  : read address (master -> slave)
//   imem_ack   : read data valid, may come in the same cycle as req (slave -> master)
//   imem_rdata : read data, valid with ack (slave -> master)
interface inst_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/inst_fetch_hold_buf.sv
// rtl/inst_fetch_hold_buf.sv - one-entry {pc, inst} buffer for a fetch returning under stall
//   clk, rst          : clock, synchronous active-high reset
//   load, load_pc/inst: capture an entry
//   unload, clear     : empty the buffer (clear wins over load)
//   valid, buf_pc/inst: buffer contents
module ifetch_hold_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [DATA_W-1:0] load_inst,
    input  logic              unload,
    input  logic              clear,
    output logic              valid,
    output logic [ADDR_W-1:0] buf_pc,
    output logic [DATA_W-1:0] buf_inst
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] inst_q, inst_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (unload) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            pc_d    = load_pc;
            inst_d  = load_inst;
        end
        if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign valid    = valid_q;
    assign buf_pc   = pc_q;
    assign buf_inst = inst_q;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with IF/ID register, hold buffer and flush drop
//   clk, rst     : clock, synchronous active-high reset
//   pc           : current PC from the pc stage
//   stall[5:0]   : ctrl stall vector (bit0 pc, bit1 IF, bit2 ID)
//   flush        : kill in-flight fetch and IF/ID contents
//   imem         : instruction-memory handshake (master side)
//   stallreq_if  : combinational fetch stall request to ctrl
//   id_pc/id_inst/id_valid : registered IF/ID outputs
//   Optional macro IFETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic [5:0]        stall,
    input  logic              flush,
    inst_fetch_if.master      imem,
    output logic              stallreq_if,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic              id_valid
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [DATA_W-1:0] id_inst_q, id_inst_d;
    logic              id_valid_q, id_valid_d;

    logic              buf_load, buf_unload, buf_clear, buf_valid;
    logic [ADDR_W-1:0] buf_pc;
    logic [DATA_W-1:0] buf_inst;

    logic              ack, stall_if, stall_id;
    logic              req, stallreq, fetch_done;
    logic              stall_unused;

    assign ack          = imem.imem_ack;
    assign stall_if     = stall[STALL_IF];
    assign stall_id     = stall[STALL_ID];
    // pc freeze and the upper stall bits belong to other stages
    assign stall_unused = ^{stall[5:3], stall[STALL_PC]};

    ifetch_hold_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hold_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .load_pc   (pc),
        .load_inst (imem.imem_rdata),
        .unload    (buf_unload),
        .clear     (buf_clear),
        .valid     (buf_valid),
        .buf_pc    (buf_pc),
        .buf_inst  (buf_inst)
    );

    always_comb begin
        state_d    = state_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        buf_load   = 1'b0;
        buf_unload = 1'b0;
        buf_clear  = 1'b0;
        req        = 1'b0;
        stallreq   = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                req      = 1'b1;
                stallreq = ~ack;
            end
            ST_DROP: begin
                stallreq = 1'b1;
            end
            default: begin
            end
        endcase

        // An instruction is accepted only from a live (non-dropped) request.
        fetch_done = (state_q == ST_FETCH) && ack;

        unique case (state_q)
            ST_FETCH: begin
                if (ack) begin
                    if (!flush && stall_if) begin
                        buf_load = 1'b1;
                        state_d  = ST_HOLD;
                    end
                end else if (flush) begin
                    // memory still owes an ack for the killed address
                    state_d = ST_DROP;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    buf_clear = 1'b1;
                    state_d   = ST_FETCH;
                end else if (!stall_if) begin
                    buf_unload = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (ack) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (flush) begin
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
        end else if (stall_if && !stall_id) begin
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
        end else if (!stall_if) begin
            if (fetch_done) begin
                id_pc_d    = pc;
                id_inst_d  = imem.imem_rdata;
                id_valid_d = 1'b1;
            end else if (state_q == ST_HOLD && buf_valid) begin
                id_pc_d    = buf_pc;
                id_inst_d  = buf_inst;
                id_valid_d = 1'b1;
            end else begin
                id_inst_d  = NOP_INST;
                id_valid_d = 1'b0;
            end
        end

        if (rst) begin
            req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            id_pc_q    <= '0;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;
    assign stallreq_if    = stallreq;
    assign id_pc          = id_pc_q;
    assign id_inst        = id_inst_q;
    assign id_valid       = id_valid_q;

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (fetch_done && !flush) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (stallreq) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
module tb_inst_fetch;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [DW-1:0] NOP = 32'h0000_0000;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] pc;
    logic [5:0]    stall;
    logic          flush;
    logic          stallreq_if;
    logic [AW-1:0] id_pc;
    logic [DW-1:0] id_inst;
    logic          id_valid;
`ifdef IFETCH_PERF_EN
    logic [31:0]   perf_fetch_cnt;
    logic [31:0]   perf_stall_cnt;
`endif

    inst_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) imem ();

    inst_fetch #(.ADDR_W(AW), .DATA_W(DW), .NOP_INST(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .stall       (stall),
        .flush       (flush),
        .imem        (imem),
        .stallreq_if (stallreq_if),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .id_valid    (id_valid)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int checks = 0;
    int passed = 0;

    // memory contents as a function of the address
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // reference model: what the stage owes decode
    bit          m_killed;
    logic [63:0] m_hold[$];
    logic [31:0] m_id_pc, m_id_inst;
    logic        m_id_valid;
    logic [31:0] m_fcnt, m_scnt;

    // memory model
    bit          mem_busy;
    int          mem_cnt;
    int          force_wait = -1;

    logic [31:0] pc_next;

    task automatic step(input logic r, input logic [5:0] s, input logic f,
                        input logic [31:0] tgt, output logic sreq_exp);
        logic ack;
        logic [31:0] rdata;
        bit fetching, got;
        int w;
        @(posedge clk);
        #1;
        chk("id_valid", {63'd0, id_valid}, {63'd0, m_id_valid});
        chk("id_inst", {32'd0, id_inst}, {32'd0, m_id_inst});
        if (m_id_valid) chk("id_pc", {32'd0, id_pc}, {32'd0, m_id_pc});
`ifdef IFETCH_PERF_EN
        chk("perf_fetch_cnt", {32'd0, perf_fetch_cnt}, {32'd0, m_fcnt});
        chk("perf_stall_cnt", {32'd0, perf_stall_cnt}, {32'd0, m_scnt});
`endif
        pc    = pc_next;
        rst   = r;
        stall = s;
        flush = f;
        #1;
        ack   = 1'b0;
        rdata = $urandom;
        if (r) begin
            mem_busy = 0;
        end else if (mem_busy) begin
            if (mem_cnt == 0) begin
                ack      = 1'b1;
                // address held stable by the stage, so data follows the current pc
                rdata    = inst_of(imem.imem_addr);
                mem_busy = 0;
            end else begin
                mem_cnt--;
            end
        end else if (imem.imem_req) begin
            w = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
            if (w == 0) begin
                ack   = 1'b1;
                rdata = inst_of(imem.imem_addr);
            end else begin
                mem_busy = 1;
                mem_cnt  = w - 1;
            end
        end
        imem.imem_ack   = ack;
        imem.imem_rdata = rdata;
        #1;
        fetching = !m_killed && (m_hold.size() == 0);
        sreq_exp = m_killed ? 1'b1 : (fetching ? !ack : 1'b0);
        if (!r) begin
            chk("imem_req", {63'd0, imem.imem_req}, {63'd0, fetching});
            if (fetching) chk("imem_addr", {32'd0, imem.imem_addr}, {32'd0, pc});
            chk("stallreq_if", {63'd0, stallreq_if}, {63'd0, sreq_exp});
        end
        got = fetching && ack && !r;
        if (r) begin
            m_killed = 0;
            m_hold.delete();
            m_id_pc = 0; m_id_inst = NOP; m_id_valid = 0;
            m_fcnt = 0; m_scnt = 0;
        end else begin
            if (got && !f) m_fcnt++;
            if (sreq_exp) m_scnt++;
            if (f) begin
                m_id_inst  = NOP;
                m_id_valid = 0;
                m_hold.delete();
                m_killed = (fetching || m_killed) && !ack;
            end else begin
                if (m_killed && ack) m_killed = 0;
                if (s[1]) begin
                    if (!s[2]) begin
                        m_id_inst = NOP; m_id_valid = 0;
                    end
                    if (got) m_hold.push_back({pc, inst_of(pc)});
                end else if (got) begin
                    m_id_pc = pc; m_id_inst = inst_of(pc); m_id_valid = 1;
                end else if (m_hold.size() != 0) begin
                    {m_id_pc, m_id_inst} = m_hold.pop_front();
                    m_id_valid = 1;
                end else begin
                    m_id_inst = NOP; m_id_valid = 0;
                end
            end
        end
        // behaviour of the pc stage and ctrl
        if (r) pc_next = 0;
        else if (f) pc_next = tgt;
        else if (!s[0] && !sreq_exp) pc_next = pc + 32'd4;
        else pc_next = pc;
    endtask

    initial begin
        logic sr;
        int nstall;
        logic [5:0] spat;
        logic r, f;
        rst = 1'b1; pc = 0; stall = 0; flush = 0; pc_next = 0;
        imem.imem_ack = 1'b0; imem.imem_rdata = '0;
        m_killed = 0; m_id_pc = 0; m_id_inst = NOP; m_id_valid = 0;
        m_fcnt = 0; m_scnt = 0; mem_busy = 0; mem_cnt = 0;

        step(1'b1, 6'd0, 1'b0, 32'd0, sr);
        step(1'b1, 6'd0, 1'b0, 32'd0, sr);
        chk("lit_rst_valid", {63'd0, id_valid}, 64'd0);
        chk("lit_rst_inst", {32'd0, id_inst}, 64'd0);
        chk("lit_rst_pc", {32'd0, id_pc}, 64'd0);

        // zero-wait stream then a two-wait-state fetch at 0xC
        force_wait = 0;
        nstall = 0;
        step(1'b0, 6'd0, 1'b0, 32'd0, sr); nstall += int'(sr);
        step(1'b0, 6'd0, 1'b0, 32'd0, sr); nstall += int'(sr);
        chk("lit_pc0", {32'd0, id_pc}, 64'h0);
        chk("lit_valid0", {63'd0, id_valid}, 64'd1);
        chk("lit_inst0", {32'd0, id_inst}, {32'd0, inst_of(32'h0)});
        step(1'b0, 6'd0, 1'b0, 32'd0, sr); nstall += int'(sr);
        chk("lit_pc4", {32'd0, id_pc}, 64'h4);
        chk("lit_zero_wait_stallreq", 64'(nstall), 64'd0);
        force_wait = 2;
        nstall = 0;
        step(1'b0, 6'd0, 1'b0, 32'd0, sr); nstall += int'(sr);
        force_wait = 0;
        chk("lit_pc8", {32'd0, id_pc}, 64'h8);
        step(1'b0, 6'd0, 1'b0, 32'd0, sr); nstall += int'(sr);
        chk("lit_bubble1", {63'd0, id_valid}, 64'd0);
        step(1'b0, 6'd0, 1'b0, 32'd0, sr); nstall += int'(sr);
        chk("lit_bubble2", {32'd0, id_inst}, 64'd0);
        step(1'b0, 6'd0, 1'b0, 32'd0, sr); nstall += int'(sr);
        chk("lit_pcC", {32'd0, id_pc}, 64'hC);
        chk("lit_instC", {32'd0, id_inst}, {32'd0, inst_of(32'hC)});
        chk("lit_wait_stallreq", 64'(nstall), 64'd2);

        // randomized phase
        force_wait = -1;
        spat = 6'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 2))
                    0: spat = 6'b000000;
                    1: spat = 6'b000011;
                    default: spat = 6'b000111;
                endcase
            end
            r = ($urandom_range(0, 399) == 0);
            f = ($urandom_range(0, 19) == 0);
            step(r, spat, f, {16'd0, 16'($urandom) & 16'hFFFC}, sr);
        end
        step(1'b0, 6'd0, 1'b0, 32'd0, sr);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
